ex_mult_seq: RTL

EX_MULT_SEQ -- requirements
Module: ex_mult_seq

---
 rtl/ex_pkg.sv | 17 +
 rtl/ex_mult_step.sv | 25 ++
 rtl/ex_mult_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared types for the ex_* execution-unit blocks: the multiplier FSM state
// and the per-operation mode latched with Start.
package ex_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    typedef struct packed {
        logic signed_op;
        logic sel_b;
    } mult_mode_t;

endpackage

// File: rtl/ex_mult_step.sv
// One shift-add step: adds multiplicand * digit into the upper half of the
// accumulator, then shifts the whole accumulator right by RADIX_BITS.
module ex_mult_step #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic [2*WIDTH-1:0]    acc,
    input  logic [WIDTH-1:0]      mcand,
    input  logic [RADIX_BITS-1:0] digit,
    output logic [2*WIDTH-1:0]    acc_next
);

    logic [WIDTH+RADIX_BITS-1:0]   partial;
    logic [WIDTH+RADIX_BITS-1:0]   sum;
    logic [2*WIDTH+RADIX_BITS-1:0] joined;

    // The sum cannot overflow W+R bits: (2^W-1) + (2^W-1)(2^R-1) < 2^(W+R).
    always_comb begin
        partial  = {{RADIX_BITS{1'b0}}, mcand} * {{WIDTH{1'b0}}, digit};
        sum      = {{RADIX_BITS{1'b0}}, acc[2*WIDTH-1:WIDTH]} + partial;
        joined   = {sum, acc[WIDTH-1:0]};
        acc_next = joined[2*WIDTH+RADIX_BITS-1:RADIX_BITS];
    end

endmodule

// File: rtl/ex_mult_seq.sv
// Sequential sign/magnitude multiplier: retires RADIX_BITS multiplier bits per
// cycle, applies sign correction in FIX, and registers the product and flags.
module ex_mult_seq
    import ex_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 Start,
    input  logic                 Flush,
    input  logic                 Signed,
    input  logic                 SelB,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Out,
    output logic                 C,
    output logic                 Z,
    output logic                 O,
    output logic                 N
);

    localparam int NSTEP = WIDTH / RADIX_BITS;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    if ((RADIX_BITS < 1) || (WIDTH < 4) || ((WIDTH % 2) != 0) ||
        ((WIDTH % RADIX_BITS) != 0)) begin : g_bad_param
        $error("ex_mult_seq: WIDTH must be even, >= 4 and divisible by RADIX_BITS");
    end

    mult_state_t          state, state_next;
    mult_mode_t           mode_in;
    logic                 signed_q;
    logic                 neg_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_step;
    logic [CNT_W-1:0]     cnt_q;

    logic [WIDTH-1:0]     b_eff;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   result;
    logic                 ovf;
    logic                 start_ok;
    logic                 fix_commit;

    // Operand conditioning; the negation of the minimum value yields 2^(W-1)
    // as an unsigned magnitude, so that case needs no special handling.
    always_comb begin
        mode_in = '{signed_op: Signed, sel_b: SelB};
        b_eff   = mode_in.sel_b ? B : {{(WIDTH-1){1'b0}}, 1'b1};
        a_neg   = mode_in.signed_op & A[WIDTH-1];
        b_neg   = mode_in.signed_op & b_eff[WIDTH-1];
        mag_a   = a_neg ? -A : A;
        mag_b   = b_neg ? -b_eff : b_eff;
    end

    ex_mult_step #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_step (
        .acc      (acc_q),
        .mcand    (mcand_q),
        .digit    (mplier_q[RADIX_BITS-1:0]),
        .acc_next (acc_step)
    );

    always_comb begin
        result = neg_q ? -acc_q : acc_q;
        if (signed_q) begin
            ovf = (result[2*WIDTH-1:WIDTH] != {WIDTH{result[WIDTH-1]}});
        end else begin
            ovf = (result[2*WIDTH-1:WIDTH] != '0);
        end
    end

    // NOTE: every output of a combinational block is given a default first so
    // that no path through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        start_ok   = 1'b0;
        fix_commit = 1'b0;
        case (state)
            IDLE: begin
                if (Start && !Flush) begin
                    start_ok   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (Flush) begin
                    state_next = IDLE;
                end else if (cnt_q == CNT_W'(NSTEP - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                Busy = 1'b1;
                if (Flush) begin
                    state_next = IDLE;
                end else begin
                    fix_commit = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: all datapath registers are reset, not just control, so a reset
    // mid-operation leaves no stale operand, count or product behind.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            signed_q <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_ok) begin
            signed_q <= mode_in.signed_op;
            neg_q    <= a_neg ^ b_neg;
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state == RUN) begin
            acc_q    <= acc_step;
            mplier_q <= mplier_q >> RADIX_BITS;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // Result and flags move only on a committed FIX; a flush leaves them alone.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            Out <= '0;
            C   <= 1'b0;
            Z   <= 1'b0;
            O   <= 1'b0;
            N   <= 1'b0;
        end else if (fix_commit) begin
            Out <= result;
            C   <= ovf;
            O   <= ovf;
            Z   <= (result[WIDTH-1:0] == '0);
            N   <= result[WIDTH-1];
        end
    end

endmodule
